// File: rtl/uni_pkg.sv
// uni_pkg: shared types for the uni result buffer (entry layout, controller states).
package uni_pkg;
  localparam int UNI_W = 4;
  typedef struct packed {
    logic             mode;
    logic [UNI_W-1:0] data;
  } uni_entry_t;
  typedef enum logic [1:0] {EMPTY, PARTIAL, FULL} fifo_state_e;
endpackage

// File: rtl/uni_fifo_ptr.sv
// uni_fifo_ptr: wrapping FIFO pointer with increment enable and synchronous reset.
module uni_fifo_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] ptr_o
);
  logic [W-1:0] ptr_q, ptr_d;
  assign ptr_d = ptr_q + W'(inc_i);
  always_ff @(posedge clk) ptr_q <= rst ? '0 : ptr_d;
  assign ptr_o = ptr_q;
endmodule

// File: rtl/uni_result_fifo.sv
// uni_result_fifo: registered valid/ready FIFO for uni results with occupancy and sticky overflow.
// Defining UNI_FIFO_STATS_EN adds a saturating accepted-push counter on push_cnt.
module uni_result_fifo import uni_pkg::*; #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic                     in_mode,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic                     out_mode,
  output logic [WIDTH-1:0]         out_data,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic                     overflow
`ifdef UNI_FIFO_STATS_EN
  , output logic [7:0]             push_cnt
`endif
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  logic [WIDTH:0]  mem [DEPTH];
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count_q, count_d;
  fifo_state_e     state_q, state_d;
  logic            overflow_q, push, pop;
  assign full      = state_q == FULL;
  assign empty     = state_q == EMPTY;
  assign in_ready  = !full;
  assign out_valid = !empty;
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign count     = count_q;
  assign overflow  = overflow_q;
  assign {out_mode, out_data} = mem[rd_ptr];
  uni_fifo_ptr #(.W(PW)) u_wr (.clk(clk), .rst(rst), .inc_i(push), .ptr_o(wr_ptr));
  uni_fifo_ptr #(.W(PW)) u_rd (.clk(clk), .rst(rst), .inc_i(pop),  .ptr_o(rd_ptr));
  always_ff @(posedge clk) if (push && !rst) mem[wr_ptr] <= {in_mode, in_data};
  assign count_d = count_q + CW'(push) - CW'(pop);
  // State mirrors count so full/empty come straight from a register.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   state_d = push ? PARTIAL : EMPTY;
      PARTIAL: state_d = (push && !pop && count_q == CW'(DEPTH-1)) ? FULL
                       : (pop && !push && count_q == CW'(1)) ? EMPTY : PARTIAL;
      FULL:    state_d = pop ? PARTIAL : FULL;
      default: state_d = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    state_q    <= rst ? EMPTY : state_d;
    count_q    <= rst ? '0 : count_d;
    overflow_q <= rst ? 1'b0 : overflow_q | (in_valid & full);
  end
`ifdef UNI_FIFO_STATS_EN
  logic [7:0] push_cnt_q, push_cnt_d;
  assign push_cnt_d = (push && push_cnt_q != 8'hFF) ? push_cnt_q + 8'd1 : push_cnt_q;
  always_ff @(posedge clk) push_cnt_q <= rst ? '0 : push_cnt_d;
  assign push_cnt = push_cnt_q;
`endif
endmodule

// File: tb/tb_uni_result_fifo.sv
// tb_uni_result_fifo: self-checking bench for uni_result_fifo against a queue-based model.
module tb_uni_result_fifo;
  logic       clk = 0, rst = 0, in_valid = 0, in_mode = 0, out_ready = 0;
  logic [3:0] in_data = 0;
  logic       in_ready, out_valid, out_mode, full, empty, overflow;
  logic [3:0] out_data;
  logic [2:0] count;
`ifdef UNI_FIFO_STATS_EN
  logic [7:0] push_cnt;
`endif
  int n_chk = 0, n_fail = 0;
  logic [4:0] q [$];
  logic       m_ovf = 0;
  int         m_pc = 0;

  uni_result_fifo #(.WIDTH(4), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_mode(in_mode), .in_data(in_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_mode(out_mode), .out_data(out_data),
    .out_ready(out_ready), .count(count), .full(full), .empty(empty), .overflow(overflow)
`ifdef UNI_FIFO_STATS_EN
    , .push_cnt(push_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic step(input logic v, input logic m, input logic [3:0] d, input logic r, input logic rs);
    bit do_push, do_pop;
    in_valid = v; in_mode = m; in_data = d; out_ready = r; rst = rs;
    do_push = v && q.size() < 4;
    do_pop  = r && q.size() > 0;
    @(posedge clk);
    if (rs) begin
      q.delete(); m_ovf = 0; m_pc = 0;
    end else begin
      if (v && q.size() == 4) m_ovf = 1;
      if (do_pop) void'(q.pop_front());
      if (do_push) begin q.push_back({m, d}); if (m_pc < 255) m_pc++; end
    end
    #1;
    in_valid = 0; out_ready = 0; rst = 0;
  endtask

  task automatic test_reset;
    step(0, 0, 0, 0, 1);
    n_chk++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count got %0d want 0", count); end
    n_chk++; if (empty !== 1'b1 || full !== 1'b0) begin n_fail++; $display("FAIL reset_flags empty=%b full=%b want 1/0", empty, full); end
    n_chk++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_hs in_ready=%b out_valid=%b want 1/0", in_ready, out_valid); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf got %b want 0", overflow); end
  endtask

  task automatic test_fill_drain;
    logic [3:0] dv [4];
    dv = '{4'd1, 4'd2, 4'd3, 4'd4};
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      step(1, i[0], dv[i], 0, 0);
      n_chk++; if (count !== 3'(i + 1)) begin n_fail++; $display("FAIL fill_count got %0d want %0d", count, i + 1); end
    end
    n_chk++; if (full !== 1'b1 || in_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full full=%b in_ready=%b want 1/0", full, in_ready); end
    n_chk++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL fill_noovf got %b want 0", overflow); end
    step(1, 0, 4'hF, 0, 0);
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_set got %b want 1", overflow); end
    n_chk++; if (count !== 3'd4 || out_data !== 4'd1) begin n_fail++; $display("FAIL ovf_hold count=%0d head=%0d want 4/1", count, out_data); end
    for (int i = 0; i < 4; i++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== dv[i] || out_mode !== i[0]) begin
        n_fail++; $display("FAIL drain_%0d valid=%b data=%0d mode=%b want 1/%0d/%b", i, out_valid, out_data, out_mode, dv[i], i[0]);
      end
      step(0, 0, 0, 1, 0);
    end
    n_chk++; if (empty !== 1'b1 || count !== 3'd0) begin n_fail++; $display("FAIL drain_empty empty=%b count=%0d want 1/0", empty, count); end
    n_chk++; if (overflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky got %b want 1", overflow); end
  endtask

  task automatic test_stream;
    logic [3:0] d;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 40; i++) begin
      d = 4'(i) ^ 4'($urandom_range(0, 1) * 5);
      step(1, i[0], d, 1, 0);
      n_chk++;
      if (count !== 3'd1 || out_valid !== 1'b1 || out_data !== d || out_mode !== i[0]) begin
        n_fail++; $display("FAIL stream_%0d count=%0d valid=%b data=%0d mode=%b want 1/1/%0d/%b", i, count, out_valid, out_data, out_mode, d, i[0]);
      end
    end
  endtask

  task automatic test_full_both;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) step(1, 1'($urandom), 4'($urandom), 0, 0);
    step(1, 1, 4'hA, 1, 0);
    n_chk++; if (count !== 3'd3 || full !== 1'b0) begin n_fail++; $display("FAIL fullboth_count count=%0d full=%b want 3/0", count, full); end
    while (q.size() > 0) begin
      n_chk++;
      if ({out_mode, out_data} !== q[0]) begin n_fail++; $display("FAIL fullboth_data got %h want %h", {out_mode, out_data}, q[0]); end
      step(0, 0, 0, 1, 0);
    end
    n_chk++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fullboth_empty got %b want 1", empty); end
  endtask

  task automatic test_empty_both;
    step(0, 0, 0, 0, 1);
    step(1, 1, 4'h6, 1, 0);
    n_chk++; if (count !== 3'd1 || out_valid !== 1'b1) begin n_fail++; $display("FAIL emptyboth count=%0d valid=%b want 1/1", count, out_valid); end
    n_chk++; if ({out_mode, out_data} !== 5'h16) begin n_fail++; $display("FAIL emptyboth_data got %h want 16", {out_mode, out_data}); end
  endtask

  task automatic test_reset_mid;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(1, 0, 4'(i), 0, 0);
    step(0, 0, 0, 1, 0);
    n_chk++; if (count !== 3'd3 || overflow !== 1'b1) begin n_fail++; $display("FAIL premid count=%0d ovf=%b want 3/1", count, overflow); end
    step(1, 1, 4'h9, 1, 1);
    n_chk++; if (count !== 3'd0 || empty !== 1'b1 || overflow !== 1'b0 || out_valid !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid count=%0d empty=%b ovf=%b valid=%b want 0/1/0/0", count, empty, overflow, out_valid);
    end
  endtask

  task automatic test_random;
    step(0, 0, 0, 0, 1);
    for (int i = 0; i < 300; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 4'($urandom), 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 60) == 0));
      n_chk++;
      if (count !== 3'(q.size()) || full !== (q.size() == 4) || empty !== (q.size() == 0) || overflow !== m_ovf) begin
        n_fail++; $display("FAIL rand_state_%0d count=%0d full=%b empty=%b ovf=%b want %0d/%0d/ovf %b", i, count, full, empty, overflow, q.size(), q.size() == 4, m_ovf);
      end
      if (q.size() > 0) begin
        n_chk++;
        if ({out_mode, out_data} !== q[0]) begin n_fail++; $display("FAIL rand_data_%0d got %h want %h", i, {out_mode, out_data}, q[0]); end
      end
    end
  endtask

`ifdef UNI_FIFO_STATS_EN
  task automatic test_stats;
    step(0, 0, 0, 0, 1);
    n_chk++; if (push_cnt !== 8'd0) begin n_fail++; $display("FAIL stats_rst got %0d want 0", push_cnt); end
    for (int i = 0; i < 300; i++) begin
      step(1, 0, 4'($urandom), 1, 0);
      if (i == 99) begin
        n_chk++; if (push_cnt !== 8'(m_pc)) begin n_fail++; $display("FAIL stats_100 got %0d want %0d", push_cnt, m_pc); end
      end
    end
    n_chk++; if (push_cnt !== 8'd255) begin n_fail++; $display("FAIL stats_sat got %0d want 255", push_cnt); end
  endtask
`endif

  initial begin
    test_reset;
    test_fill_drain;
    test_stream;
    test_full_both;
    test_empty_both;
    test_reset_mid;
    test_random;
`ifdef UNI_FIFO_STATS_EN
    test_stats;
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/uni_result_fifo.md
# uni_result_fifo

Registered result buffer sitting directly downstream of the combinational `uni` unit. It captures each `uni` result (4-bit `c` plus the mode bit `b` that produced it) under a valid/ready handshake and holds it in a small FIFO until the consumer takes it. It also tracks occupancy and flags dropped pushes. This decouples the `uni` output from the consumer's timing.

## Interface
Parameters:
- `WIDTH`, 4: data width; matches `uni` port `c`.
- `DEPTH`, 4: number of entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  producer presents a result this cycle.
- `in_mode`  in  1  `b` value used by `uni` for this result.
- `in_data`  in  WIDTH  `c` output of `uni`.
- `in_ready`  out  1  FIFO can accept a push; equals `!full`.
- `out_valid`  out  1  head entry available; equals `!empty`.
- `out_mode`  out  1  mode bit of the head entry.
- `out_data`  out  WIDTH  data of the head entry.
- `out_ready`  in  1  consumer takes the head entry this cycle.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `full`  out  1  `count == DEPTH`.
- `empty`  out  1  `count == 0`.
- `overflow`  out  1  sticky; set when a push is attempted while full.
- `push_cnt`  out  8  only with `UNI_FIFO_STATS_EN`; saturating count of accepted pushes.

## Operation
- Push: `push = in_valid && in_ready`. On push, write `{in_mode, in_data}` to `mem[wr_ptr]` and advance `wr_ptr`.
- Pop: `pop = out_valid && out_ready`. On pop, advance `rd_ptr`.
- Pointers are $clog2(DEPTH) bits wide and wrap from DEPTH-1 to 0 by natural overflow.
- `count` changes by +1 on push only, −1 on pop only, and 0 on both or neither.
- Push and pop in the same cycle:
  - When not empty and not full, both take effect and `count` is unchanged.
  - When empty, only the push occurs, because `out_valid` is 0.
  - When full, only the pop occurs, because `in_ready` is 0. There is no write-through-when-full.
- Overflow:
  - `in_valid && full` sets `overflow` on the next edge.
  - The data is dropped. `wr_ptr` and `count` are unchanged.
  - `overflow` clears only on `rst`.
- `out_mode` and `out_data` are a combinational read of `mem[rd_ptr]`. Their value is don't-care while `out_valid` is 0.
- Storage contents are not reset. The bench must check data only when `out_valid` is high.
- Controller FSM, derived from `count`:
  - States are EMPTY, PARTIAL and FULL.
  - EMPTY→PARTIAL on push.
  - PARTIAL→FULL on a push without pop when `count == DEPTH-1`.
  - PARTIAL→EMPTY on a pop without push when `count == 1`.
  - FULL→PARTIAL on pop.

## Timing
- Reset values:
  - `count` = 0, `wr_ptr` = `rd_ptr` = 0.
  - `empty` = 1, `full` = 0, `in_ready` = 1, `out_valid` = 0.
  - `overflow` = 0, `push_cnt` = 0.
  - `out_data` and `out_mode` are X (don't-care).
- Latency:
  - A push in cycle N makes the entry visible on `out_*` with `out_valid` = 1 in cycle N+1.
  - There is no combinational path from `in_*` to `out_*`.
- `in_ready` and `out_valid` depend only on registered state. Neither depends combinationally on `in_valid` or `out_ready`.
- Throughput is one push and one pop per cycle in steady state.
- `rst` asserted mid-operation: all contents are discarded, and the outputs show the reset values in the cycle after the edge where `rst` is sampled high. A push or pop in the same cycle as `rst` is ignored.

## Configuration
- Macro: `UNI_FIFO_STATS_EN`.
- Defined:
  - The `push_cnt` port and its register exist.
  - It increments by 1 per accepted push and saturates at 255.
  - It resets to 0.
  - Rejected pushes are not counted.
- Undefined: no `push_cnt` port and no register. All other behaviour is identical.

## Structure
- Shared package `uni_pkg` holds:
  - `UNI_W` = 4.
  - The entry typedef `uni_entry_t` = `{logic mode; logic [UNI_W-1:0] data;}`.
  - The FSM state enum `fifo_state_e` {EMPTY, PARTIAL, FULL}.
- Sub-module `uni_fifo_ptr`: a wrapping pointer with an increment enable and synchronous reset, instantiated twice (write and read pointers).
- `uni_result_fifo` owns the storage array, `count`, the FSM, `overflow` and the optional stats counter.

## Test plan
- After reset, 4 pushes of (`b`,`c`) = (0,1),(1,2),(0,3),(1,4) with `out_ready` = 0:
  - `count` reaches 4, `full` = 1, `in_ready` = 0.
  - Then `out_ready` = 1 pops in the same order: `out_data` 1,2,3,4 and `out_mode` 0,1,0,1.
- 5th push of data 0xF while full:
  - `overflow` = 1 from the next cycle.
  - `count` stays 4 and the head is still 1.
  - `overflow` stays 1 after every entry has been drained.
- Continuous push and pop with `out_ready` = 1, for `a` = 0..15 and `b` toggling through `uni`:
  - `count` stays at 1 in steady state.
  - Outputs match the pushed values one cycle later, across 4+ pointer wraps.
- Push and pop together at `count` = 4: `count` becomes 3 and the pushed value is not stored.
- At `count` = 0 with `in_valid` = 1 and `out_ready` = 1: `count` becomes 1 and `out_valid` rises the next cycle.
- `rst` pulsed with `count` = 3 and `overflow` = 1:
  - Next cycle: `count` = 0, `empty` = 1, `overflow` = 0.
  - With `UNI_FIFO_STATS_EN`: after 300 accepted pushes, `push_cnt` = 255.
